// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the ALU sequencer: opcodes, ALU select codes,
// FSM state encoding and operand widths.
package alu_sequencer_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NUM_REGS = 8;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;

    localparam logic [2:0] SEL_PASS = 3'b000;
    localparam logic [2:0] SEL_ADD  = 3'b001;
    localparam logic [2:0] SEL_AND  = 3'b010;
    localparam logic [2:0] SEL_OR   = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    // Two's-complement negation; sub is add with a negated second operand.
    function automatic logic [DATA_W-1:0] negate8(input logic [DATA_W-1:0] v);
        return (~v) + 8'd1;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of instruction handshake, external ALU, write-back and debug signals.
interface alu_sequencer_if;
    import alu_sequencer_pkg::*;

    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] alu_data1;
    logic [DATA_W-1:0] alu_data2;
    logic [2:0]        alu_select;
    logic [DATA_W-1:0] alu_result;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              err;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output instr, instr_valid, alu_result, dbg_addr,
        input  instr_ready, alu_data1, alu_data2, alu_select,
               wb_valid, wb_addr, wb_data, err, dbg_data
    );

    modport slave (
        input  instr, instr_valid, alu_result, dbg_addr,
        output instr_ready, alu_data1, alu_data2, alu_select,
               wb_valid, wb_addr, wb_data, err, dbg_data
    );
endinterface

// File: rtl/alu_sequencer_reg_file.sv
// 8 x 8-bit register file: two operand read ports, one debug read port,
// one synchronous write port.
module reg_file
    import alu_sequencer_pkg::*;
(
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Storage: cleared on reset, one register written per enabled edge.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1   = regs[raddr1];
    assign rdata2   = regs[raddr2];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer driving an external combinational ALU.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ST_IDLE   | instr_ready high, waiting for instr_valid
//  ST_DECODE | read R[SRC1]/R[SRC2], classify opcode, stage ALU operands
//  ST_EXEC   | ALU operands driven, alu_result captured at end of cycle
//  ST_WB     | wb_valid pulse, R[DEST] written at end of cycle
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic           CLK,
    input  logic           RESETn,
    alu_sequencer_if.slave bus
);

    state_t            state;
    logic [7:0]        op;
    logic [ADDR_W-1:0] dest;
    logic [ADDR_W-1:0] src1;
    logic [7:0]        src2;
    logic              ready;
    logic [2:0]        sel;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              err;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              unused_fields;

    assign unused_fields = ^{bus.instr[23:19], bus.instr[15:11]};

    // wb_valid is high only during WB, so it doubles as the write enable;
    // the write lands on the edge that ends WB.
    reg_file u_reg_file (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .we       (wb_valid),
        .waddr    (wb_addr),
        .wdata    (wb_data),
        .raddr1   (src1),
        .raddr2   (src2[ADDR_W-1:0]),
        .dbg_addr (bus.dbg_addr),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .dbg_data (bus.dbg_data)
    );

    // Sequencing FSM with all outputs registered.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state    <= ST_IDLE;
            op       <= '0;
            dest     <= '0;
            src1     <= '0;
            src2     <= '0;
            ready    <= 1'b1;
            sel      <= SEL_PASS;
            data1    <= '0;
            data2    <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            err      <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        op    <= bus.instr[31:24];
                        dest  <= bus.instr[18:16];
                        src1  <= bus.instr[10:8];
                        src2  <= bus.instr[7:0];
                        ready <= 1'b0;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state <= ST_EXEC;
                    data1 <= '0;
                    case (op)
                        OP_LOADI: begin
                            sel   <= SEL_PASS;
                            data2 <= src2;
                        end
                        OP_MOV: begin
                            sel   <= SEL_PASS;
                            data2 <= rdata2;
                        end
                        OP_ADD: begin
                            sel   <= SEL_ADD;
                            data1 <= rdata1;
                            data2 <= rdata2;
                        end
                        OP_SUB: begin
                            sel   <= SEL_ADD;
                            data1 <= rdata1;
                            data2 <= negate8(rdata2);
                        end
                        OP_AND: begin
                            sel   <= SEL_AND;
                            data1 <= rdata1;
                            data2 <= rdata2;
                        end
                        OP_OR: begin
                            sel   <= SEL_OR;
                            data1 <= rdata1;
                            data2 <= rdata2;
                        end
                        default: begin
                            // Illegal opcode: flag it and drop the instruction.
                            err   <= 1'b1;
                            ready <= 1'b1;
                            state <= ST_IDLE;
                        end
                    endcase
                end
                ST_EXEC: begin
                    wb_data  <= bus.alu_result;
                    wb_addr  <= dest;
                    wb_valid <= 1'b1;
                    sel      <= SEL_PASS;
                    data1    <= '0;
                    data2    <= '0;
                    state    <= ST_WB;
                end
                ST_WB: begin
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.instr_ready = ready;
    assign bus.alu_select  = sel;
    assign bus.alu_data1   = data1;
    assign bus.alu_data2   = data2;
    assign bus.wb_valid    = wb_valid;
    assign bus.wb_addr     = wb_addr;
    assign bus.wb_data     = wb_data;
    assign bus.err         = err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural external ALU,
// a register-file model and a write-back scoreboard.
module tb_alu_sequencer;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
    } wb_t;

    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    logic [7:0] alu_res;

    int errors = 0;
    int checks = 0;
    logic [7:0] mdl [8];
    wb_t sb [$];

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    // External ALU
    always_comb begin
        case (bus.alu_select)
            3'b000:  alu_res = bus.alu_data2;
            3'b001:  alu_res = bus.alu_data1 + bus.alu_data2;
            3'b010:  alu_res = bus.alu_data1 & bus.alu_data2;
            3'b011:  alu_res = bus.alu_data1 | bus.alu_data2;
            default: alu_res = 8'h00;
        endcase
    end
    assign bus.alu_result = alu_res;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk_instr(input logic [7:0] op, input logic [2:0] dest,
                                             input logic [2:0] s1, input logic [7:0] s2);
        return {op, 5'b10101, dest, 5'b01010, s1, s2};
    endfunction

    // Expected EXEC outputs and result computed from the register model.
    task automatic expect_op(input logic [7:0] op, input logic [2:0] s1, input logic [7:0] s2,
                             output logic [2:0] e_sel, output logic [7:0] e_d1,
                             output logic [7:0] e_d2, output logic [7:0] e_res);
        logic [7:0] a;
        logic [7:0] b;
        a = mdl[s1];
        b = mdl[s2[2:0]];
        e_sel = 3'b000; e_d1 = 8'h00; e_d2 = 8'h00; e_res = 8'h00;
        case (op)
            8'h00: begin e_d2 = s2; e_res = s2; end
            8'h01: begin e_d2 = b; e_res = b; end
            8'h02: begin e_sel = 3'b001; e_d1 = a; e_d2 = b; e_res = a + b; end
            8'h03: begin e_sel = 3'b001; e_d1 = a; e_d2 = 8'h00 - b; e_res = a - b; end
            8'h04: begin e_sel = 3'b010; e_d1 = a; e_d2 = b; e_res = a & b; end
            8'h05: begin e_sel = 3'b011; e_d1 = a; e_d2 = b; e_res = a | b; end
            default: ;
        endcase
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge CLK);
            if (bus.instr_ready === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_ready: instr_ready=%b required 1 within 20 cycles", bus.instr_ready);
        end
    endtask

    task automatic pop_compare(input string name);
        wb_t exp_wb;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: wb_valid with empty scoreboard (wb_addr=%0d wb_data=%h)",
                     name, bus.wb_addr, bus.wb_data);
        end else begin
            exp_wb = sb.pop_front();
            if (bus.wb_addr !== exp_wb.addr || bus.wb_data !== exp_wb.data) begin
                errors++;
                $display("FAIL %s: wb_addr=%0d wb_data=%h required wb_addr=%0d wb_data=%h",
                         name, bus.wb_addr, bus.wb_data, exp_wb.addr, exp_wb.data);
            end
        end
    endtask

    // Issue one legal instruction and follow it through DECODE, EXEC and WB.
    task automatic run_instr(input string name, input logic [7:0] op, input logic [2:0] dest,
                             input logic [2:0] s1, input logic [7:0] s2);
        logic [2:0] e_sel;
        logic [7:0] e_d1, e_d2, e_res;
        wb_t ent;
        wait_ready();
        expect_op(op, s1, s2, e_sel, e_d1, e_d2, e_res);
        bus.instr = mk_instr(op, dest, s1, s2);
        bus.instr_valid = 1'b1;
        ent.addr = dest;
        ent.data = e_res;
        sb.push_back(ent);
        mdl[dest] = e_res;
        @(posedge CLK);
        @(negedge CLK);
        bus.instr_valid = 1'b0;
        bus.instr = 32'hFFFF_FFFF;
        checks++;
        if (bus.instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s decode_ready: instr_ready=%b required 0", name, bus.instr_ready);
        end
        @(negedge CLK);
        checks++;
        if (bus.alu_select !== e_sel || bus.alu_data1 !== e_d1 || bus.alu_data2 !== e_d2
            || bus.wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s exec: sel=%b d1=%h d2=%h wb_valid=%b required sel=%b d1=%h d2=%h wb_valid=0",
                     name, bus.alu_select, bus.alu_data1, bus.alu_data2, bus.wb_valid, e_sel, e_d1, e_d2);
        end
        @(negedge CLK);
        checks++;
        if (bus.wb_valid !== 1'b1 || bus.alu_select !== 3'b000 || bus.alu_data2 !== 8'h00) begin
            errors++;
            $display("FAIL %s wb: wb_valid=%b sel=%b d2=%h required wb_valid=1 sel=000 d2=00",
                     name, bus.wb_valid, bus.alu_select, bus.alu_data2);
        end
        if (bus.wb_valid === 1'b1) pop_compare(name);
        bus.dbg_addr = dest;
        @(negedge CLK);
        checks++;
        if (bus.dbg_data !== e_res || bus.wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s dbg: dbg_data=%h wb_valid=%b required dbg_data=%h wb_valid=0",
                     name, bus.dbg_data, bus.wb_valid, e_res);
        end
    endtask

    task automatic check_all_regs(input string name);
        for (int r = 0; r < 8; r++) begin
            bus.dbg_addr = 3'(r);
            #1;
            checks++;
            if (bus.dbg_data !== mdl[r]) begin
                errors++;
                $display("FAIL %s R%0d: dbg_data=%h required %h", name, r, bus.dbg_data, mdl[r]);
            end
        end
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        for (int r = 0; r < 8; r++) mdl[r] = 8'h00;
        repeat (2) @(negedge CLK);
        checks++;
        if (bus.instr_ready !== 1'b1 || bus.wb_valid !== 1'b0 || bus.err !== 1'b0
            || bus.wb_addr !== 3'd0 || bus.wb_data !== 8'h00 || bus.alu_select !== 3'b000
            || bus.alu_data1 !== 8'h00 || bus.alu_data2 !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b wb_valid=%b err=%b wb_addr=%0d wb_data=%h sel=%b d1=%h d2=%h required 1 0 0 0 00 000 00 00",
                     bus.instr_ready, bus.wb_valid, bus.err, bus.wb_addr, bus.wb_data,
                     bus.alu_select, bus.alu_data1, bus.alu_data2);
        end
        check_all_regs("reset_regs");
        @(negedge CLK);
        RESETn = 1'b1;
    endtask

    task automatic test_arith();
        run_instr("loadi_r1", 8'h00, 3'd1, 3'd0, 8'd10);
        run_instr("loadi_r2", 8'h00, 3'd2, 3'd0, 8'd20);
        run_instr("add_r3",   8'h02, 3'd3, 3'd1, 8'd2);
        run_instr("sub_r4",   8'h03, 3'd4, 3'd2, 8'd1);
        run_instr("and_r5",   8'h04, 3'd5, 3'd1, 8'd2);
        run_instr("or_r6",    8'h05, 3'd6, 3'd1, 8'd2);
        run_instr("mov_r7",   8'h01, 3'd7, 3'd0, 8'd3);
        check_all_regs("arith_regs");
    endtask

    task automatic test_wrap();
        run_instr("loadi_ff", 8'h00, 3'd1, 3'd0, 8'hFF);
        run_instr("add_wrap", 8'h02, 3'd0, 3'd1, 8'd1);
    endtask

    task automatic test_illegal();
        wait_ready();
        bus.instr = mk_instr(8'h07, 3'd3, 3'd1, 8'd2);
        bus.instr_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.instr_valid = 1'b0;
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_err_early: err=%b required 0", bus.err);
        end
        @(negedge CLK);
        checks++;
        if (bus.err !== 1'b1 || bus.wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_err_pulse: err=%b wb_valid=%b required err=1 wb_valid=0",
                     bus.err, bus.wb_valid);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            checks++;
            if (bus.err !== 1'b0 || bus.wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL illegal_after_%0d: err=%b wb_valid=%b required 0 0",
                         c, bus.err, bus.wb_valid);
            end
        end
        check_all_regs("illegal_regs");
    endtask

    task automatic test_reset_inflight();
        wb_t ent;
        wait_ready();
        bus.instr = mk_instr(8'h02, 3'd3, 3'd1, 8'd2);
        bus.instr_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.instr_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.alu_select !== 3'b001) begin
            errors++;
            $display("FAIL abort_exec_sel: alu_select=%b required 001", bus.alu_select);
        end
        RESETn = 1'b0;
        for (int r = 0; r < 8; r++) mdl[r] = 8'h00;
        #1;
        checks++;
        if (bus.instr_ready !== 1'b1 || bus.wb_valid !== 1'b0 || bus.alu_select !== 3'b000) begin
            errors++;
            $display("FAIL abort_immediate: ready=%b wb_valid=%b sel=%b required 1 0 000",
                     bus.instr_ready, bus.wb_valid, bus.alu_select);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            checks++;
            if (bus.instr_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_hold_%0d: ready=%b wb_valid=%b required 1 0",
                         c, bus.instr_ready, bus.wb_valid);
            end
        end
        check_all_regs("abort_regs");
        // Release and present an instruction straight away.
        RESETn = 1'b1;
        bus.instr = mk_instr(8'h00, 3'd2, 3'd0, 8'd5);
        bus.instr_valid = 1'b1;
        ent.addr = 3'd2;
        ent.data = 8'd5;
        sb.push_back(ent);
        mdl[2] = 8'd5;
        @(posedge CLK);
        @(negedge CLK);
        bus.instr_valid = 1'b0;
        checks++;
        if (bus.instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL resume_accept: instr_ready=%b required 0", bus.instr_ready);
        end
        repeat (2) @(negedge CLK);
        checks++;
        if (bus.wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL resume_wb: wb_valid=%b required 1", bus.wb_valid);
        end else begin
            pop_compare("resume_wb");
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ops [4];
        logic [7:0] s2s [4];
        logic [2:0] e_sel;
        logic [7:0] e_d1, e_d2, e_res;
        wb_t ent;
        int idx, readies, pops;
        ops[0] = 8'h00; s2s[0] = 8'd7;
        ops[1] = 8'h02; s2s[1] = 8'd1;
        ops[2] = 8'h02; s2s[2] = 8'd1;
        ops[3] = 8'h02; s2s[3] = 8'd1;
        idx = 0; readies = 0; pops = 0;
        wait_ready();
        bus.instr_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge CLK);
            if (bus.wb_valid === 1'b1) begin
                pops++;
                pop_compare("b2b_wb");
            end
            if (bus.instr_ready === 1'b1) begin
                readies++;
                if (idx < 4) begin
                    expect_op(ops[idx], 3'd1, s2s[idx], e_sel, e_d1, e_d2, e_res);
                    bus.instr = mk_instr(ops[idx], 3'd1, 3'd1, s2s[idx]);
                    ent.addr = 3'd1;
                    ent.data = e_res;
                    sb.push_back(ent);
                    mdl[1] = e_res;
                end else begin
                    bus.instr = mk_instr(8'h00, 3'd6, 3'd0, 8'hAA);
                end
                idx++;
            end
        end
        bus.instr_valid = 1'b0;
        checks++;
        if (readies != 4 || pops != 4 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_rate: readies=%0d wb=%0d pending=%0d required 4 4 0",
                     readies, pops, sb.size());
        end
        @(negedge CLK);
        bus.dbg_addr = 3'd1;
        #1;
        checks++;
        if (bus.dbg_data !== 8'd56) begin
            errors++;
            $display("FAIL b2b_final_r1: dbg_data=%h required 38", bus.dbg_data);
        end
    endtask

    initial begin
        bus.instr = 32'h0;
        bus.instr_valid = 1'b0;
        bus.dbg_addr = 3'd0;
        test_reset();
        test_arith();
        test_wrap();
        test_illegal();
        test_reset_inflight();
        test_back_to_back();
        repeat (2) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1, single clock; all state rising-edge.
REQ-002 SHALL have port RESETn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port instr, input, 32, instruction: OP[31:24], DEST[18:16], SRC1[10:8], SRC2/IMM[7:0].
REQ-004 SHALL have port instr_valid, input, 1, instr is valid this cycle.
REQ-005 SHALL have port instr_ready, output, 1, block accepts an instruction this cycle.
REQ-006 SHALL have port alu_data1, output, 8, ALU operand 1.
REQ-007 SHALL have port alu_data2, output, 8, ALU operand 2.
REQ-008 SHALL have port alu_select, output, 3, ALU op: 000 forward data2, 001 add, 010 and, 011 or.
REQ-009 SHALL have port alu_result, input, 8, combinational result from the external ALU.
REQ-010 SHALL have port wb_valid, output, 1, one-cycle pulse when a register is written.
REQ-011 SHALL have port wb_addr, output, 3, register written.
REQ-012 SHALL have port wb_data, output, 8, value written.
REQ-013 SHALL have port err, output, 1, one-cycle pulse on illegal opcode.
REQ-014 SHALL have port dbg_addr, input, 3, debug read address.
REQ-015 SHALL have port dbg_data, output, 8, combinational read of register dbg_addr.

Function
REQ-016 SHALL hold an internal 8 x 8-bit register file R0..R7, written only in WB.
REQ-017 SHALL implement FSM IDLE -> DECODE -> EXEC -> WB -> IDLE; one state per cycle.
REQ-018 SHALL assert instr_ready only in IDLE; instruction accepted when instr_valid and instr_ready are both high; instr latched then.
REQ-019 SHALL in DECODE read SRC1/SRC2 and classify OP: 0x00 loadi, 0x01 mov, 0x02 add, 0x03 sub, 0x04 and, 0x05 or.
REQ-020 SHALL on any other OP pulse err in the cycle after DECODE, skip EXEC/WB, return to IDLE, leave registers unchanged.
REQ-021 SHALL in EXEC drive: loadi -> sel 000, data2=IMM; mov -> sel 000, data2=R[SRC2]; add/and/or -> sel 001/010/011, data1=R[SRC1], data2=R[SRC2]; sub -> sel 001, data2=(~R[SRC2])+1 (mod 256).
REQ-022 SHALL register alu_result at the end of EXEC; outputs stable for the whole EXEC cycle.
REQ-023 SHALL outside EXEC drive alu_select=000, alu_data1=0, alu_data2=0.
REQ-024 SHALL in WB write R[DEST] and pulse wb_valid with wb_addr=DEST, wb_data=captured result.
REQ-025 SHALL use 8-bit wrap-around arithmetic; no carry/overflow flag.
REQ-026 SHALL read operands in DECODE after the previous WB committed, so back-to-back dependent instructions see updated values.
REQ-027 SHALL have accept-to-wb_valid latency of 3 cycles; max throughput one instruction per 4 cycles.
REQ-028 SHALL ignore instr_valid outside IDLE; instr need not be held after acceptance.
REQ-029 SHALL report R[dbg_addr] on dbg_data including the value written in the same WB cycle only after the edge.

Reset
REQ-030 SHALL on RESETn low immediately: FSM -> IDLE, R0..R7=0, instr_ready=1, wb_valid=0, err=0, wb_addr=0, wb_data=0, alu outputs=0.
REQ-031 SHALL abort any in-flight instruction on reset with no write-back; accepting resumes on the first edge after RESETn rises.

Structure
REQ-032 SHALL place opcode constants, ALU select codes and FSM state encodings in a shared package.
REQ-033 SHALL implement the register file as sub-module reg_file (2 read ports plus debug read, 1 write port).
REQ-034 SHALL not contain an ALU; arithmetic except sub negation is done by the external ALU.

Verification
REQ-035 SHALL cover: loadi R1,10; loadi R2,20; add R3,R1,R2 -> wb_data=30, wb_addr=3, alu_select=001 in EXEC.
REQ-036 SHALL cover: sub R4,R2,R1 (20-10) -> alu_data2=0xF6, wb_data=10; and R5,R1,R2 -> 0; or R6,R1,R2 -> 30.
REQ-037 SHALL cover: loadi R1,0xFF; add R0,R1,R1 -> wb_data=0xFE (wrap).
REQ-038 SHALL cover: OP=0x07 -> err pulse 2 cycles after accept, no wb_valid, dbg_data unchanged for all registers.
REQ-039 SHALL cover: RESETn low during EXEC of add R3 -> no wb_valid, R3 reads 0, instr_ready high while reset.
REQ-040 SHALL cover: instr_valid held high continuously -> instr_ready high 1 cycle in 4, exactly one accept per IDLE.
